// File: rtl/k12a_lcd_ctl.sv
// HD44780 character LCD sequencer: power-on init, then one byte write per
// valid/ready handshake with setup / enable-pulse / hold / settle timing.
module k12a_lcd_ctl #(
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 12,
  parameter int HOLD_CYCLES       = 2,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 80000,
  parameter int POWERUP_CYCLES    = 1000000
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int MAX_A  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_B  = (HOLD_CYCLES > CMD_WAIT_CYCLES) ? HOLD_CYCLES : CMD_WAIT_CYCLES;
  localparam int MAX_C  = (CLEAR_WAIT_CYCLES > POWERUP_CYCLES) ? CLEAR_WAIT_CYCLES : POWERUP_CYCLES;
  localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_ALL = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CW = $clog2(MAX_ALL) + 1;

  typedef enum logic [2:0] {
    POWERUP    = 3'd0,
    INIT_ISSUE = 3'd1,
    IDLE       = 3'd2,
    SETUP      = 3'd3,
    PULSE      = 3'd4,
    HOLD       = 3'd5,
    WAIT       = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, en_d;
  logic          rw_q, rw_d;
  logic          ready_q, ready_d;
  logic          init_done_q, init_done_d;
  logic          issue_s;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 8'h38;
      3'd1:    init_cmd = 8'h0C;
      3'd2:    init_cmd = 8'h06;
      3'd3:    init_cmd = 8'h01;
      default: init_cmd = 8'h00;
    endcase
  endfunction

  // Clear (0x01) and home (0x02/0x03) commands need the long settle time.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    is_slow_cmd = (rs == 1'b0) && (data[7:2] == 6'd0) && (data != 8'h00);
  endfunction

  // Next-state, counter and pin-value computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    issue_s     = 1'b0;
    case (state_q)
      POWERUP: begin
        if (cnt_q == CW'(0)) issue_s = 1'b1;
        else                 cnt_d = cnt_q - CW'(1);
      end
      INIT_ISSUE: issue_s = 1'b1;
      IDLE: begin
        if (req_valid && ready_q) begin
          rs_d    = req_rs;
          data_d  = req_data;
          state_d = SETUP;
          cnt_d   = CW'(SETUP_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(0)) begin
          state_d = PULSE;
          cnt_d   = CW'(PULSE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PULSE: begin
        if (cnt_q == CW'(0)) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CW'(0)) begin
          state_d = WAIT;
          if (is_slow_cmd(rs_q, data_q)) cnt_d = CW'(CLEAR_WAIT_CYCLES - 1);
          else                           cnt_d = CW'(CMD_WAIT_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT: begin
        if (cnt_q == CW'(0)) begin
          if (init_done_q) state_d = IDLE;
          else             issue_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = POWERUP;
        cnt_d   = CW'(POWERUP_CYCLES - 1);
      end
    endcase

    // INIT_ISSUE is resolved on the same edge that leaves POWERUP/WAIT, so
    // the init sequence costs no extra cycles per command.
    if (issue_s) begin
      if (idx_q == 3'd4) begin
        state_d     = IDLE;
        init_done_d = 1'b1;
      end else begin
        rs_d    = 1'b0;
        data_d  = init_cmd(idx_q);
        idx_d   = idx_q + 3'd1;
        state_d = SETUP;
        cnt_d   = CW'(SETUP_CYCLES - 1);
      end
    end else begin
      idx_d = idx_d;
    end

    en_d    = (state_d == PULSE);
    rw_d    = 1'b0;
    ready_d = (state_d == IDLE) && init_done_d;
  end

  // State and pin registers; reset is the POWERUP entry, so the counter
  // starts preloaded with the power-up delay.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q     <= POWERUP;
      cnt_q       <= CW'(POWERUP_CYCLES - 1);
      idx_q       <= 3'd0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready = ready_q;
  assign init_done = init_done_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = rw_q;
  assign lcd_en    = en_q;
  assign lcd_data  = data_q;

endmodule

// File: tb/tb_k12a_lcd_ctl.sv
// Directed bench for k12a_lcd_ctl with short timing parameters
// (S=2, P=3, H=2, CMD_WAIT=5, CLEAR_WAIT=20, POWERUP=10).
module tb_k12a_lcd_ctl;

  logic       sys_clock = 1'b0;
  logic       reset     = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs    = 1'b0;
  logic [7:0] req_data  = 8'h00;
  logic       req_ready, init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  int errors = 0;
  int checks = 0;
  int e      = 0;

  k12a_lcd_ctl #(
    .SETUP_CYCLES(2), .PULSE_CYCLES(3), .HOLD_CYCLES(2),
    .CMD_WAIT_CYCLES(5), .CLEAR_WAIT_CYCLES(20), .POWERUP_CYCLES(10)
  ) dut (
    .sys_clock(sys_clock), .reset(reset),
    .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
    .req_ready(req_ready), .init_done(init_done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic tick();
    @(posedge sys_clock);
    #1;
    e++;
  endtask

  task automatic release_reset();
    @(negedge sys_clock);
    reset = 1'b0;
    e = 0;
  endtask

  // Expected init schedule: command i enters SETUP at edge 10+12*i,
  // EN high after edges start+2..start+4, done after edge 73.
  task automatic run_init_check();
    logic [7:0] cmds [4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
    for (int t = 1; t <= 73; t++) begin
      logic       exp_en;
      logic [7:0] exp_data;
      int         i;
      tick();
      exp_en = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (t >= 10 + 12*c + 2 && t <= 10 + 12*c + 4) exp_en = 1'b1;
      end
      if (t < 10) begin
        exp_data = 8'h00;
      end else begin
        i = (t - 10) / 12;
        if (i > 3) i = 3;
        exp_data = cmds[i];
      end
      chk("init_en", {31'd0, lcd_en}, {31'd0, exp_en});
      chk("init_data", {24'd0, lcd_data}, {24'd0, exp_data});
      chk("init_rs", {31'd0, lcd_rs}, 32'd0);
      chk("init_rw", {31'd0, lcd_rw}, 32'd0);
      chk("init_ready", {31'd0, req_ready}, {31'd0, (t == 73)});
      chk("init_done", {31'd0, init_done}, {31'd0, (t == 73)});
    end
  endtask

  task automatic handshake(input logic rs, input logic [7:0] data);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = data;
    tick();
    chk("hs_rs", {31'd0, lcd_rs}, {31'd0, rs});
    chk("hs_data", {24'd0, lcd_data}, {24'd0, data});
    chk("hs_ready_low", {31'd0, req_ready}, 32'd0);
    chk("hs_en_low", {31'd0, lcd_en}, 32'd0);
  endtask

  // Follow one write after its handshake edge; EN high after k+2..k+4,
  // ready back after k+7+w.
  task automatic run_busy(input logic rs, input logic [7:0] data, input int w,
                          input bit toggle, input logic [7:0] final_data,
                          input bit drop_valid);
    int total;
    total = 7 + w;
    for (int j = 1; j <= total; j++) begin
      tick();
      chk("busy_en", {31'd0, lcd_en}, {31'd0, (j >= 2 && j <= 4)});
      chk("busy_rs", {31'd0, lcd_rs}, {31'd0, rs});
      chk("busy_data", {24'd0, lcd_data}, {24'd0, data});
      chk("busy_ready", {31'd0, req_ready}, {31'd0, (j == total)});
      if (toggle) begin
        if (j >= total - 1) req_data = final_data;
        else                req_data = (j % 2 == 1) ? 8'hFF : 8'h00;
      end
      if (drop_valid && j == total - 1) req_valid = 1'b0;
    end
  endtask

  initial begin
    // Reset state, including behaviour across clock edges while held.
    #1;
    chk("rst_en", {31'd0, lcd_en}, 32'd0);
    tick(); tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_done", {31'd0, init_done}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'd0);

    // 1: power-on init with no request
    release_reset();
    run_init_check();

    // 2: data write rs=1 0x41
    handshake(1'b1, 8'h41);
    req_valid = 1'b0;
    run_busy(1'b1, 8'h41, 5, 1'b0, 8'h00, 1'b0);

    // 3: clear, home, and a normal command
    handshake(1'b0, 8'h01);
    req_valid = 1'b0;
    run_busy(1'b0, 8'h01, 20, 1'b0, 8'h00, 1'b0);
    handshake(1'b0, 8'h02);
    req_valid = 1'b0;
    run_busy(1'b0, 8'h02, 20, 1'b0, 8'h00, 1'b0);
    handshake(1'b0, 8'h80);
    req_valid = 1'b0;
    run_busy(1'b0, 8'h80, 5, 1'b0, 8'h00, 1'b0);

    // 4: back-to-back with req_valid held, req_data toggling while busy
    handshake(1'b1, 8'h48);
    run_busy(1'b1, 8'h48, 5, 1'b1, 8'h49, 1'b0);
    tick();
    chk("b2b_second_data", {24'd0, lcd_data}, 32'h49);
    chk("b2b_second_ready", {31'd0, req_ready}, 32'd0);
    run_busy(1'b1, 8'h49, 5, 1'b1, 8'h49, 1'b1);
    tick();
    chk("b2b_no_third", {31'd0, req_ready}, 32'd1);
    chk("b2b_no_third_en", {31'd0, lcd_en}, 32'd0);

    // 5: reset asserted mid-pulse
    handshake(1'b1, 8'h5A);
    req_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_en", {31'd0, lcd_en}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_en", {31'd0, lcd_en}, 32'd0);
    chk("async_rs", {31'd0, lcd_rs}, 32'd0);
    chk("async_data", {24'd0, lcd_data}, 32'd0);
    chk("async_ready", {31'd0, req_ready}, 32'd0);
    chk("async_done", {31'd0, init_done}, 32'd0);
    chk("async_rw", {31'd0, lcd_rw}, 32'd0);
    tick(); tick();
    release_reset();
    run_init_check();

    // 6: request pending throughout init
    reset = 1'b1;
    tick();
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h55;
    release_reset();
    run_init_check();
    tick();
    chk("init_req_rs", {31'd0, lcd_rs}, 32'd1);
    chk("init_req_data", {24'd0, lcd_data}, 32'h55);
    chk("init_req_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    run_busy(1'b1, 8'h55, 5, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
